tcam_index_decoder: RTL and testbench
=====================================

TCAM_INDEX_DECODER -- requirements
Module: tcam_index_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the bitmap width; legal range is WIDTH >= 2, and WIDTH need not be a power of two.
REQ-002 SHALL have derived localparam IW = $clog2(WIDTH), the index width.
REQ-003 SHALL have derived localparam CW = $clog2(WIDTH)+1, the beat-count width.
REQ-004 axis_aclk  input  1  sole clock; all logic is rising-edge.
REQ-005 axis_resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 in_index  input  IW  encoded index of one set bit.
REQ-007 in_last  input  1  marks the final beat of a group.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-010 out_unencoded  output  WIDTH  decoded bitmap of the group.
REQ-011 out_count  output  CW  number of beats accepted in the group.
REQ-012 out_err  output  1  group contained at least one index >= WIDTH.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  output beat consumed when out_valid and out_ready are both high.

Function
REQ-015 SHALL perform the inverse of the team's priority encoder: it turns a stream of encoded indices into one bitmap per group.
REQ-016 SHALL hold internal accumulator registers acc_map (WIDTH bits), acc_cnt (CW bits) and acc_err (1 bit).
REQ-017 SHALL hold an output register set with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-019 On an accepted beat with in_index < WIDTH, SHALL OR bit in_index into the group bitmap; a duplicate index leaves the bitmap unchanged.
REQ-020 On an accepted beat with in_index >= WIDTH, SHALL leave the bitmap unchanged and set the group error flag.
REQ-021 Every accepted beat SHALL increment the group count, including duplicate and errored beats.
REQ-022 The group count SHALL saturate at 2^CW-1 and SHALL never wrap.
REQ-023 On an accepted beat with in_last=0, SHALL update acc_map, acc_cnt and acc_err.
REQ-024 On an accepted beat with in_last=1, SHALL load out_unencoded with acc_map merged with this beat's decode.
REQ-025 On that same edge, SHALL load out_count with the incremented, saturated acc_cnt.
REQ-026 On that same edge, SHALL load out_err with acc_err merged with this beat's error.
REQ-027 On that same edge, SHALL clear acc_map, acc_cnt and acc_err to 0 and set out_valid=1 (state FULL).
REQ-028 Latency SHALL be one cycle from the accepted in_last beat to out_valid=1.
REQ-029 Throughput SHALL be one beat per cycle, including back-to-back single-beat groups while out_ready=1.
REQ-030 Output handshake with no accepted last beat on the same cycle SHALL give out_valid=0 next cycle; the output data registers keep their previous values.
REQ-031 Output handshake and an accepted last beat on the same cycle SHALL reload the output registers and keep out_valid=1 with no bubble.
REQ-032 In FULL with out_ready=0, SHALL hold out_unencoded, out_count, out_err and out_valid stable and SHALL deassert in_ready.
REQ-033 in_valid=0 SHALL leave all state unchanged, except for the output handshake.

Reset
REQ-034 While axis_resetn=0, SHALL asynchronously force out_valid=0, out_unencoded=0, out_count=0, out_err=0, acc_map=0, acc_cnt=0, acc_err=0.
REQ-035 Reset during a partial group or while FULL SHALL discard all pending data; nothing SHALL be emitted after release.
REQ-036 in_ready SHALL be 1 while in reset and immediately after release, following REQ-018.

Verification
REQ-037 WIDTH=64, out_ready=1; beats 3, 17, 63(last) -> one cycle later out_valid=1, bitmap bits 3,17,63 set, out_count=3, out_err=0.
REQ-038 WIDTH=64; single-beat groups 0, 1, 2 on consecutive cycles, each with last -> out_valid high three consecutive cycles with bitmaps 0x1, 0x2, 0x4, out_count=1 each.
REQ-039 WIDTH=5 (IW=3); beats 2, 6, 2(last) -> out_unencoded=5'b00100, out_count=3, out_err=1.
REQ-040 out_ready=0 with FULL holding group A; present group B -> in_ready=0, A held stable; raise out_ready -> A consumed and B accepted on the same edge, B output next cycle.
REQ-041 WIDTH=2 (CW=2); four beats of index 1, last on the fourth -> out_count=3 (saturated), out_unencoded=2'b10.
REQ-042 Assert axis_resetn=0 after two non-last beats, then release and send index 5 with last -> output bitmap has only bit 5 set, out_count=1.

Source files
------------

// File: rtl/tcam_index_decoder.sv
// Collects a stream of encoded indices into one bitmap per group. The result appears one cycle after the last beat.
// Backpressure: in_ready drops only while a result is held and out_ready is low, so the output register can be reloaded on the same cycle it is consumed.
module tcam_index_decoder #(
  parameter int  WIDTH = 64,
  localparam int IW    = $clog2(WIDTH),
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             axis_aclk,
  input  logic             axis_resetn,
  input  logic [IW-1:0]    in_index,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_unencoded,
  output logic [CW-1:0]    out_count,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [IW:0] LIM = (IW + 1)'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc_map, r_out_map, w_beat_map, w_map_nxt;
  logic [CW-1:0]    r_acc_cnt, r_out_cnt, w_cnt_nxt;
  logic             r_acc_err, r_out_err, w_err_nxt;
  logic             w_idx_ok, w_fire, w_fire_last;

  assign in_ready    = (r_state == EMPTY) || out_ready;
  assign w_fire      = in_valid && in_ready;
  assign w_fire_last = w_fire && in_last;
  assign w_idx_ok    = {1'b0, in_index} < LIM;

  // Out-of-range indices match no bit position, so they leave the bitmap untouched.
  always_comb begin
    w_beat_map = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_index == IW'(i)) w_beat_map[i] = 1'b1;
    end
  end

  assign w_map_nxt = r_acc_map | w_beat_map;
  assign w_cnt_nxt = (&r_acc_cnt) ? r_acc_cnt : r_acc_cnt + CW'(1);
  assign w_err_nxt = r_acc_err | ~w_idx_ok;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_fire_last) w_state_nxt = FULL;
      FULL: begin
        if (w_fire_last)    w_state_nxt = FULL;
        else if (out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state   <= EMPTY;
      r_acc_map <= '0;
      r_acc_cnt <= '0;
      r_acc_err <= 1'b0;
      r_out_map <= '0;
      r_out_cnt <= '0;
      r_out_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        if (in_last) begin
          r_acc_map <= '0;
          r_acc_cnt <= '0;
          r_acc_err <= 1'b0;
          r_out_map <= w_map_nxt;
          r_out_cnt <= w_cnt_nxt;
          r_out_err <= w_err_nxt;
        end else begin
          r_acc_map <= w_map_nxt;
          r_acc_cnt <= w_cnt_nxt;
          r_acc_err <= w_err_nxt;
        end
      end
    end
  end

  assign out_valid     = (r_state == FULL);
  assign out_unencoded = r_out_map;
  assign out_count     = r_out_cnt;
  assign out_err       = r_out_err;

endmodule

// File: tb/tb_tcam_index_decoder.sv
// Bench for tcam_index_decoder at WIDTH 64, 5 and 2.
// Expected groups are queued at issue time and checked by per-instance monitors on output handshakes.
module tb_tcam_index_decoder;

  typedef struct packed {
    logic [63:0] map;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  logic clk, rstn;

  logic [5:0]  i64;
  logic        l64, v64, r64, or64, ov64, e64;
  logic [63:0] om64;
  logic [6:0]  c64;

  logic [2:0]  i5;
  logic        l5, v5, r5, or5, ov5, e5;
  logic [4:0]  om5;
  logic [3:0]  c5;

  logic [0:0]  i2;
  logic        l2, v2, r2, or2, ov2, e2;
  logic [1:0]  om2;
  logic [1:0]  c2;

  exp_t q64[$], q5[$], q2[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  tcam_index_decoder #(.WIDTH(64)) d64 (
    .axis_aclk(clk), .axis_resetn(rstn), .in_index(i64), .in_last(l64), .in_valid(v64),
    .in_ready(r64), .out_unencoded(om64), .out_count(c64), .out_err(e64),
    .out_valid(ov64), .out_ready(or64));

  tcam_index_decoder #(.WIDTH(5)) d5 (
    .axis_aclk(clk), .axis_resetn(rstn), .in_index(i5), .in_last(l5), .in_valid(v5),
    .in_ready(r5), .out_unencoded(om5), .out_count(c5), .out_err(e5),
    .out_valid(ov5), .out_ready(or5));

  tcam_index_decoder #(.WIDTH(2)) d2 (
    .axis_aclk(clk), .axis_resetn(rstn), .in_index(i2), .in_last(l2), .in_valid(v2),
    .in_ready(r2), .out_unencoded(om2), .out_count(c2), .out_err(e2),
    .out_valid(ov2), .out_ready(or2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void push(input int d, input logic [63:0] m, input int c, input bit e);
    exp_t x;
    x.map = m;
    x.cnt = 8'(c);
    x.err = e;
    case (d)
      0:       q64.push_back(x);
      1:       q5.push_back(x);
      default: q2.push_back(x);
    endcase
  endfunction

  function automatic logic rdy(input int d);
    case (d)
      0:       return r64;
      1:       return r5;
      default: return r2;
    endcase
  endfunction

  task automatic beat(input int d, input int idx, input bit last);
    int n = 0;
    case (d)
      0:       begin i64 = 6'(idx); l64 = last; v64 = 1'b1; end
      1:       begin i5  = 3'(idx); l5  = last; v5  = 1'b1; end
      default: begin i2  = 1'(idx); l2  = last; v2  = 1'b1; end
    endcase
    @(negedge clk);
    while (!rdy(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(d)) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: in_ready got 0, required 1 (dut %0d)", d);
    end
    @(posedge clk);
    #1;
    v64 = 1'b0;
    v5  = 1'b0;
    v2  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && ov64 && or64) begin
      if (q64.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m64_unexpected: got map %h, required no output", om64);
      end else begin
        e = q64.pop_front();
        chk("m64_map", om64, e.map);
        chk("m64_cnt", 64'(c64), 64'(e.cnt));
        chk("m64_err", 64'(e64), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn && ov5 && or5) begin
      if (q5.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m5_unexpected: got map %h, required no output", om5);
      end else begin
        e = q5.pop_front();
        chk("m5_map", 64'(om5), e.map);
        chk("m5_cnt", 64'(c5), 64'(e.cnt));
        chk("m5_err", 64'(e5), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn && ov2 && or2) begin
      if (q2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m2_unexpected: got map %h, required no output", om2);
      end else begin
        e = q2.pop_front();
        chk("m2_map", 64'(om2), e.map);
        chk("m2_cnt", 64'(c2), 64'(e.cnt));
        chk("m2_err", 64'(e2), 64'(e.err));
      end
    end
  end

  initial begin
    logic [63:0] map_a;
    int n;
    rstn = 1'b0;
    i64 = '0; l64 = 1'b0; v64 = 1'b0; or64 = 1'b1;
    i5  = '0; l5  = 1'b0; v5  = 1'b0; or5  = 1'b1;
    i2  = '0; l2  = 1'b0; v2  = 1'b0; or2  = 1'b1;

    #2;
    chk("rst_valid", 64'(ov64), 64'd0);
    chk("rst_map",   om64,      64'd0);
    chk("rst_cnt",   64'(c64),  64'd0);
    chk("rst_err",   64'(e64),  64'd0);
    chk("rst_rdy",   64'(r64),  64'd1);
    chk("rst_valid5", 64'(ov5), 64'd0);
    chk("rst_valid2", 64'(ov2), 64'd0);
    #20 rstn = 1'b1;
    chk("rel_rdy", 64'(r64), 64'd1);
    @(posedge clk); #1;

    // Three-beat group, one-cycle latency, then drain keeps data.
    map_a = (64'd1 << 3) | (64'd1 << 17) | (64'd1 << 63);
    push(0, map_a, 3, 1'b0);
    beat(0, 3, 1'b0);
    beat(0, 17, 1'b0);
    beat(0, 63, 1'b1);
    chk("lat_valid", 64'(ov64), 64'd1);
    @(posedge clk); #1;
    chk("drain_valid", 64'(ov64), 64'd0);
    chk("drain_hold",  om64, map_a);

    // Back-to-back single-beat groups.
    push(0, 64'h1, 1, 1'b0);
    push(0, 64'h2, 1, 1'b0);
    push(0, 64'h4, 1, 1'b0);
    beat(0, 0, 1'b1);
    chk("b2b_v0", 64'(ov64), 64'd1);
    beat(0, 1, 1'b1);
    chk("b2b_v1", 64'(ov64), 64'd1);
    chk("b2b_m1", om64, 64'h2);
    beat(0, 2, 1'b1);
    chk("b2b_v2", 64'(ov64), 64'd1);
    chk("b2b_m2", om64, 64'h4);
    @(posedge clk); #1;

    // Stall with group A held, group B waiting, then simultaneous consume/accept.
    or64 = 1'b0;
    push(0, 64'd1 << 10, 1, 1'b0);
    beat(0, 10, 1'b1);
    chk("stall_full", 64'(ov64), 64'd1);
    i64 = 6'd20; l64 = 1'b1; v64 = 1'b1;
    push(0, 64'd1 << 20, 1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("stall_rdy", 64'(r64),  64'd0);
      chk("stall_map", om64,      64'd1 << 10);
      chk("stall_vld", 64'(ov64), 64'd1);
    end
    @(posedge clk); #1;
    or64 = 1'b1;
    @(negedge clk);
    chk("release_rdy", 64'(r64), 64'd1);
    @(posedge clk); #1;
    v64 = 1'b0;
    chk("b_vld", 64'(ov64), 64'd1);
    chk("b_map", om64, 64'd1 << 20);
    @(posedge clk); #1;
    chk("b_drain", 64'(ov64), 64'd0);

    // Non-power-of-two width: out-of-range indices set the error flag.
    push(1, 64'h04, 3, 1'b1);
    beat(1, 2, 1'b0);
    beat(1, 6, 1'b0);
    beat(1, 2, 1'b1);
    push(1, 64'h10, 2, 1'b1);
    beat(1, 4, 1'b0);
    beat(1, 5, 1'b1);
    push(1, 64'h01, 1, 1'b0);
    beat(1, 0, 1'b1);

    // Count saturation at the narrowest width.
    push(2, 64'h2, 3, 1'b0);
    repeat (3) beat(2, 1, 1'b0);
    beat(2, 1, 1'b1);
    push(2, 64'h1, 1, 1'b0);
    beat(2, 0, 1'b1);
    @(posedge clk); #1;

    // Reset while FULL, then reset during a partial group.
    or64 = 1'b0;
    beat(0, 40, 1'b1);
    chk("full_before_rst", 64'(ov64), 64'd1);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(ov64), 64'd0);
    chk("arst_map",   om64,      64'd0);
    chk("arst_cnt",   64'(c64),  64'd0);
    chk("arst_err",   64'(e64),  64'd0);
    chk("arst_rdy",   64'(r64),  64'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(ov64), 64'd0);
    or64 = 1'b1;
    beat(0, 7, 1'b0);
    beat(0, 9, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    push(0, 64'd1 << 5, 1, 1'b0);
    beat(0, 5, 1'b1);

    n = 0;
    while ((q64.size() + q5.size() + q2.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drain", 64'(q64.size() + q5.size() + q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
